// File: rtl/regdst_pkg.sv
// regdst_pkg: shared encodings and types for the register-destination
// write-back queue.
//  - REGDST_* : RegDst select encodings (rt, rd, high constant, low constant)
//  - wb_entry_t : write-back record {addr, data, we} at the default geometry
//    (5-bit index, 32-bit data). The top level declares an equivalent local
//    struct sized by its own parameters.
package regdst_pkg;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_HI = 2'b10;
    localparam logic [1:0] REGDST_LO = 2'b11;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic                 we;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: generic DEPTH x W FIFO.
//  clk, reset      : clock, synchronous active-high reset
//  push, din       : write din at tail (caller guarantees !full || pop)
//  pop             : drop head (caller guarantees !empty)
//  dout            : head entry; while empty, holds the last popped entry
//  full, empty     : occupancy flags
//  ord_ent/ord_vld : all slots in age order (index 0 = oldest/head) with
//                    valid bits, for associative searches by the parent
module wb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0][W-1:0]   ord_ent,
    output logic [DEPTH-1:0]          ord_vld
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [W-1:0]            last_q, last_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    // Head slot is stale once drained, so fall back to the last popped entry.
    assign dout  = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);  // power-of-two depth wraps naturally
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        ord_ent = '0;
        ord_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ord_ent[i] = mem_q[rd_ptr_q + PW'(i)];
            ord_vld[i] = (CW'(i) < cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/regdst_wb_queue.sv
// regdst_wb_queue: destination-register select feeding a write-back queue
// with a two-port hazard scoreboard.
//  clk, reset            : clock, synchronous active-high reset
//  in_valid/in_ready     : request handshake; RegDst picks rt_idx, rd_idx,
//                          CONST_HI or CONST_LO; in_data/in_we carried along
//  out_valid/out_ready   : head handshake toward the register file;
//                          out_addr/out_data/out_we describe the head
//  qa_idx/qb_idx         : source indices; qa_busy/qb_busy flag a queued
//                          write to them
//  WB_BYPASS_EN (macro)  : adds qa_fwd/qb_fwd and qa_data/qb_data, carrying
//                          the youngest matching queued value for forwarding
module regdst_wb_queue
    import regdst_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int CONST_HI = 31,
    parameter int CONST_LO = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        RegDst,
    input  logic [ADDR_W-1:0] rt_idx,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    input  logic [ADDR_W-1:0] qa_idx,
    input  logic [ADDR_W-1:0] qb_idx,
`ifdef WB_BYPASS_EN
    output logic              qa_fwd,
    output logic              qb_fwd,
    output logic [DATA_W-1:0] qa_data,
    output logic [DATA_W-1:0] qb_data,
`endif
    output logic              qa_busy,
    output logic              qb_busy
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [ADDR_W-1:0]          sel_addr;
    entry_t                     in_ent, head_ent;
    logic [EW-1:0]              head_raw;
    logic [DEPTH-1:0][EW-1:0]   ord_raw;
    logic [DEPTH-1:0]           ord_vld;
    logic                       full, empty, push, pop;

    always_comb begin
        case (RegDst)
            REGDST_RT: sel_addr = rt_idx;
            REGDST_RD: sel_addr = rd_idx;
            REGDST_HI: sel_addr = ADDR_W'(CONST_HI);
            default:   sel_addr = ADDR_W'(CONST_LO);
        endcase
    end

    // r0 is hardwired: such entries still flow through but never write or
    // raise a hazard.
    always_comb begin
        in_ent.addr = sel_addr;
        in_ent.data = in_data;
        in_ent.we   = in_we && (sel_addr != '0);
    end

    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = !empty && out_ready;
    assign out_valid = !empty;

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (EW'(in_ent)),
        .dout    (head_raw),
        .full    (full),
        .empty   (empty),
        .ord_ent (ord_raw),
        .ord_vld (ord_vld)
    );

    assign head_ent = entry_t'(head_raw);
    assign out_addr = head_ent.addr;
    assign out_data = head_ent.data;
    assign out_we   = head_ent.we;

    // Scoreboard over registered contents only: the head being popped still
    // matches, an entry being pushed does not yet. Walking oldest to youngest
    // lets the last match win for the forwarded value.
    logic [DATA_W-1:0] a_val, b_val;
    always_comb begin
        entry_t e;
        qa_busy = 1'b0;
        qb_busy = 1'b0;
        a_val   = '0;
        b_val   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = entry_t'(ord_raw[i]);
            if (ord_vld[i] && e.we && (qa_idx != '0) && (e.addr == qa_idx)) begin
                qa_busy = 1'b1;
                a_val   = e.data;
            end
            if (ord_vld[i] && e.we && (qb_idx != '0) && (e.addr == qb_idx)) begin
                qb_busy = 1'b1;
                b_val   = e.data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign qa_fwd  = qa_busy;
    assign qb_fwd  = qb_busy;
    assign qa_data = a_val;
    assign qb_data = b_val;
`else
    logic unused_val;
    assign unused_val = ^{a_val, b_val};
`endif

endmodule
